// File: rtl/alu_ctrl_seq_if.sv
// EX-stage bus between Decoder/datapath and the ALU control sequencer.
// The master side drives the instruction fields; the slave side answers with control and HI/LO data.
interface alu_ctrl_seq_if #(
  parameter int DATA_W = 32
);
  logic              valid_i;
  logic [5:0]        funct_i;
  logic [3:0]        ALUOp_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [3:0]        ALUCtrl_o;
  logic              stall_o;
  logic [1:0]        hilo_sel_o;
  logic [DATA_W-1:0] hilo_data_o;
  logic              busy_o;

  modport master (
    output valid_i, funct_i, ALUOp_i, rs_data_i, rt_data_i,
    input  ALUCtrl_o, stall_o, hilo_sel_o, hilo_data_o, busy_o
  );

  modport slave (
    input  valid_i, funct_i, ALUOp_i, rs_data_i, rt_data_i,
    output ALUCtrl_o, stall_o, hilo_sel_o, hilo_data_o, busy_o
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ALU control decode plus an iterative mult/multu/div/divu sequencer owning HI/LO.
// Radix-2 shift-add multiply and restoring divide on magnitudes, sign-fixed in a final cycle.
module alu_ctrl_seq #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_ctrl_seq_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0100;
  localparam logic [3:0] ALU_SRA = 4'b0101;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;
  logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
  logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic              bzero_q, bzero_d;

  logic [3:0]          alu_ctrl;
  logic [1:0]          hilo_sel;
  logic                is_muldiv;
  logic                issue;
  logic                signed_op, a_neg, b_neg;
  logic [DATA_W-1:0]   a_abs, b_abs;
  logic [DATA_W:0]     mul_sum, div_shift;
  logic                div_ge;
  logic [DATA_W-1:0]   div_diff;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quot_fix, rem_fix;

  always_comb begin
    alu_ctrl  = ALU_ADD;
    hilo_sel  = 2'b00;
    is_muldiv = 1'b0;
    case (bus.ALUOp_i)
      4'b0000: begin
        case (bus.funct_i)
          6'b100000: alu_ctrl = ALU_ADD;
          6'b100010: alu_ctrl = ALU_SUB;
          6'b100100: alu_ctrl = ALU_AND;
          6'b100101: alu_ctrl = ALU_OR;
          6'b100111: alu_ctrl = ALU_NOR;
          6'b101010: alu_ctrl = ALU_SLT;
          6'b000000: alu_ctrl = ALU_SLL;
          6'b000010: alu_ctrl = ALU_SRL;
          6'b000011: alu_ctrl = ALU_SRA;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: is_muldiv = 1'b1;
          6'b010000: hilo_sel = 2'b10;
          6'b010010: hilo_sel = 2'b01;
          default:   alu_ctrl = ALU_ADD;
        endcase
      end
      4'b0001: alu_ctrl = ALU_ADD;
      4'b0010: alu_ctrl = ALU_SUB;
      4'b0011: alu_ctrl = ALU_AND;
      4'b0100: alu_ctrl = ALU_OR;
      4'b0101: alu_ctrl = ALU_SLT;
      default: alu_ctrl = ALU_ADD;
    endcase
  end

  // funct[0]=1 selects the unsigned variant, funct[1]=1 selects divide.
  assign issue     = (state_q == S_IDLE) && bus.valid_i && is_muldiv;
  assign signed_op = ~bus.funct_i[0];
  assign a_neg     = signed_op & bus.rs_data_i[DATA_W-1];
  assign b_neg     = signed_op & bus.rt_data_i[DATA_W-1];
  assign a_abs     = a_neg ? -bus.rs_data_i : bus.rs_data_i;
  assign b_abs     = b_neg ? -bus.rt_data_i : bus.rt_data_i;

  assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, {DATA_W{acc_lo_q[0]}} & opnd_q};
  assign div_shift = {acc_hi_q, acc_lo_q[DATA_W-1]};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_diff  = div_shift[DATA_W-1:0] - opnd_q;

  // A zero divisor leaves an all-ones quotient and |A| remainder, so only skip the quotient negation.
  assign prod_fix  = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
  assign quot_fix  = (neg_q && !bzero_q) ? -acc_lo_q : acc_lo_q;
  assign rem_fix   = rneg_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    bzero_d  = bzero_q;
    case (state_q)
      S_IDLE: begin
        if (issue) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          is_div_d = bus.funct_i[1];
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          bzero_d  = (bus.rt_data_i == '0);
          opnd_d   = bus.funct_i[1] ? b_abs : a_abs;
          acc_hi_d = '0;
          acc_lo_d = bus.funct_i[1] ? a_abs : b_abs;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_diff : div_shift[DATA_W-1:0];
          acc_lo_d = {acc_lo_q[DATA_W-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[DATA_W:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[DATA_W-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        hi_d    = is_div_q ? rem_fix  : prod_fix[2*DATA_W-1:DATA_W];
        lo_d    = is_div_q ? quot_fix : prod_fix[DATA_W-1:0];
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bzero_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bzero_q  <= bzero_d;
    end
  end

  assign bus.ALUCtrl_o   = alu_ctrl;
  assign bus.hilo_sel_o  = hilo_sel;
  assign bus.stall_o     = issue || (state_q == S_RUN) || (state_q == S_FIX);
  assign bus.busy_o      = (state_q != S_IDLE);
  assign bus.hilo_data_o = (hilo_sel == 2'b10) ? hi_q :
                           (hilo_sel == 2'b01) ? lo_q : '0;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: decode table, mul/div results, stall timing and mid-run reset.
module tb_alu_ctrl_seq;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  alu_ctrl_seq_if #(.DATA_W(32)) bus ();

  alu_ctrl_seq #(.DATA_W(32)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    bus.ALUOp_i = 4'b0000;
    bus.funct_i = 6'b010000;
    #1 chk_eq({tag, "_mfhi"}, bus.hilo_data_o, exp_hi);
    bus.funct_i = 6'b010010;
    #1 chk_eq({tag, "_mflo"}, bus.hilo_data_o, exp_lo);
  endtask

  // Issue one muldiv; with hold=1, valid stays high through DONE and operands change mid-RUN.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit hold,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    @(negedge clk);
    bus.valid_i   = 1'b1;
    bus.ALUOp_i   = 4'b0000;
    bus.funct_i   = f;
    bus.rs_data_i = a;
    bus.rt_data_i = b;
    #1;
    n = 0;
    while (bus.stall_o && n < 100) begin
      n++;
      @(negedge clk);
      if (!hold) bus.valid_i = 1'b0;
      if (hold && n == 10) begin
        bus.rs_data_i = ~a;
        bus.rt_data_i = 32'h0000_0007;
      end
      #1;
    end
    chk_eq({tag, "_stall_cycles"}, n, 32'd34);
    chk_eq({tag, "_busy_in_done"}, {31'd0, bus.busy_o}, 32'd1);
    @(negedge clk);
    bus.valid_i = 1'b0;
    #1;
    chk_eq({tag, "_busy_after"}, {31'd0, bus.busy_o}, 32'd0);
    chk_eq({tag, "_stall_after"}, {31'd0, bus.stall_o}, 32'd0);
    read_hilo(tag, exp_hi, exp_lo);
  endtask

  typedef struct {
    logic [3:0] aluop;
    logic [5:0] funct;
    logic [3:0] ctrl;
    logic [1:0] sel;
  } dec_vec_t;

  dec_vec_t dec_tbl[$];

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.valid_i   = 1'b0;
    bus.ALUOp_i   = 4'b0000;
    bus.funct_i   = 6'b010000;
    bus.rs_data_i = '0;
    bus.rt_data_i = '0;

    dec_tbl = '{
      '{4'b0000, 6'b100000, 4'b0010, 2'b00}, '{4'b0000, 6'b100010, 4'b0110, 2'b00},
      '{4'b0000, 6'b100100, 4'b0000, 2'b00}, '{4'b0000, 6'b100101, 4'b0001, 2'b00},
      '{4'b0000, 6'b100111, 4'b1100, 2'b00}, '{4'b0000, 6'b101010, 4'b0111, 2'b00},
      '{4'b0000, 6'b000000, 4'b0011, 2'b00}, '{4'b0000, 6'b000010, 4'b0100, 2'b00},
      '{4'b0000, 6'b000011, 4'b0101, 2'b00}, '{4'b0000, 6'b011000, 4'b0010, 2'b00},
      '{4'b0000, 6'b011001, 4'b0010, 2'b00}, '{4'b0000, 6'b011010, 4'b0010, 2'b00},
      '{4'b0000, 6'b011011, 4'b0010, 2'b00}, '{4'b0000, 6'b010000, 4'b0010, 2'b10},
      '{4'b0000, 6'b010010, 4'b0010, 2'b01}, '{4'b0000, 6'b111111, 4'b0010, 2'b00},
      '{4'b0001, 6'b100010, 4'b0010, 2'b00}, '{4'b0010, 6'b100000, 4'b0110, 2'b00},
      '{4'b0011, 6'b100000, 4'b0000, 2'b00}, '{4'b0100, 6'b100000, 4'b0001, 2'b00},
      '{4'b0101, 6'b100000, 4'b0111, 2'b00}, '{4'b0111, 6'b100111, 4'b0010, 2'b00}
    };

    // Reset state
    #2;
    chk_eq("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    chk_eq("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    read_hilo("rst", 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep: {ALUCtrl, hilo_sel} packed together
    foreach (dec_tbl[i]) begin
      @(negedge clk);
      bus.ALUOp_i = dec_tbl[i].aluop;
      bus.funct_i = dec_tbl[i].funct;
      #1 chk_eq($sformatf("dec_op%b_f%b", dec_tbl[i].aluop, dec_tbl[i].funct),
                {26'd0, bus.ALUCtrl_o, bus.hilo_sel_o},
                {26'd0, dec_tbl[i].ctrl, dec_tbl[i].sel});
    end
    bus.ALUOp_i = 4'b0000;
    bus.funct_i = 6'b100000;
    #1 chk_eq("hilo_data_sel00", bus.hilo_data_o, 32'h0);

    run_op("mult",     6'b011000, 32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu",    6'b011001, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("div",      6'b011010, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu",     6'b011011, 32'h0000_0064, 32'h0000_0007, 1'b0, 32'h0000_0002, 32'h0000_000E);
    run_op("divu_by0", 6'b011011, 32'h0000_000A, 32'h0000_0000, 1'b0, 32'h0000_000A, 32'hFFFF_FFFF);
    run_op("div_by0",  6'b011010, 32'hFFFF_FFF9, 32'h0000_0000, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div_ovf",  6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000);
    run_op("mult_hold", 6'b011000, 32'h0000_0007, 32'h0000_0006, 1'b1, 32'h0000_0000, 32'h0000_002A);

    // Reset during RUN cycle 10 aborts and clears HI/LO
    @(negedge clk);
    bus.valid_i   = 1'b1;
    bus.funct_i   = 6'b011000;
    bus.rs_data_i = 32'h0000_0003;
    bus.rt_data_i = 32'h0000_0004;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.valid_i = 1'b0;
    end
    #1 chk_eq("pre_rst_busy", {31'd0, bus.busy_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_eq("midrst_stall", {31'd0, bus.stall_o}, 32'd0);
    chk_eq("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    read_hilo("midrst", 32'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("mult_post_rst", 6'b011000, 32'h0000_1234, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_EDCC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
Parametrised ALU control unit for the single-cycle MIPS datapath.
- Decodes ALUOp/funct into the ALU operation code.
- Adds a multi-cycle mult/multu/div/divu sequencer with HI/LO registers and mfhi/mflo readout.
- Stalls the PC while an iterative operation is in flight.
- Sits in the EX stage between Decoder and ALU.

Parameters:
DATA_W, 32, operand/HI/LO width (even, ≥4)
CNT_W, $clog2(DATA_W)+1, iteration counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
valid_i  in  1  instruction present in EX this cycle
funct_i  in  6  instruction funct field
ALUOp_i  in  4  from Decoder
rs_data_i  in  DATA_W  operand A (dividend/multiplicand)
rt_data_i  in  DATA_W  operand B (divisor/multiplier)
ALUCtrl_o  out  4  ALU operation code
stall_o  out  1  hold PC and register-file write
hilo_sel_o  out  2  00 ALU result, 01 LO, 10 HI
hilo_data_o  out  DATA_W  selected HI/LO value (0 when hilo_sel_o=00)
busy_o  out  1  sequencer not IDLE

Behaviour:
- ALUCtrl codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 0011 SLL, 0100 SRL, 0101 SRA.
- ALUOp_i decode:
  - 0000 R-type: decode funct.
  - 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 SLT.
  - Any other ALUOp → ADD.
- R-type funct decode:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT, 000000 SLL, 000010 SRL, 000011 SRA.
  - 011000 mult, 011001 multu, 011010 div, 011011 divu (muldiv class): ALUCtrl ADD.
  - 010000 mfhi → hilo_sel 10; 010010 mflo → hilo_sel 01; both ALUCtrl ADD.
  - Unknown funct → ADD.
- ALUCtrl_o and hilo_sel_o are purely combinational and independent of valid_i and state.
- FSM states: IDLE, RUN, FIX, DONE.
  - IDLE: if valid_i & muldiv → latch |A|, |B|, op, result-sign flags; clear cnt; go RUN.
  - RUN: one radix-2 step per cycle (shift-add multiply, restoring divide); cnt++; go FIX after DATA_W steps.
  - FIX: apply sign correction; write HI/LO; go DONE.
  - DONE: one cycle; go IDLE unconditionally. valid_i/muldiv in DONE is the retiring instruction and is ignored.
- stall_o = (state==IDLE & valid_i & muldiv) | state==RUN | state==FIX.
  - Stall is high for exactly DATA_W+2 consecutive cycles per muldiv.
  - stall_o is low in DONE.
- busy_o = state≠IDLE.
- Multiply result: HI = upper DATA_W bits, LO = lower DATA_W bits of the 2·DATA_W product.
  - Signed (mult): product negated iff operand signs differ.
- Divide result: LO = quotient, HI = remainder, truncating toward zero.
  - Signed remainder takes the dividend's sign.
- Divide by zero (B=0):
  - LO = all ones; HI = dividend (raw rs_data_i); no exception.
  - Both signed and unsigned.
- Signed overflow (div, most-negative / -1): LO = most-negative, HI = 0.
- Operands are latched only at IDLE issue; changes to rs/rt during RUN are ignored.
- hilo_data_o reads HI/LO as registered; mfhi/mflo in IDLE never stalls.
  - In-order single-cycle issue guarantees no read during RUN.
  - If a read does occur during RUN/FIX, it returns the pre-operation HI/LO.
- Reset (async, rst_i=0):
  - state IDLE, cnt 0, HI 0, LO 0, operand latches 0.
  - stall_o 0, busy_o 0, hilo_data_o 0.
  - Reset mid-RUN aborts the operation; HI/LO read 0.

Test Plan:
- Decode sweep: ALUOp 0000 with every listed funct, plus ALUOp 0001–0101 and 0111 → exact ALUCtrl/hilo_sel codes above; funct 111111 → 0010.
- mult: rs=FFFFFFFD (-3), rt=00000005, valid 1 cycle then held → stall_o high exactly 34 cycles; then mfhi=FFFFFFFF, mflo=FFFFFFF1.
- multu: FFFFFFFF × 00000002 → HI=00000001, LO=FFFFFFFE. div: rs=FFFFFFF9 (-7), rt=00000002 → LO=FFFFFFFD, HI=FFFFFFFF.
- Division edges:
  - divu 0000000A/00000000 → LO=FFFFFFFF, HI=0000000A.
  - div 80000000/FFFFFFFF → LO=80000000, HI=00000000.
- Operands changed during RUN and valid_i held through DONE → results unaffected; no second operation starts; busy_o falls one cycle after stall_o.
- rst_i pulsed low in RUN cycle 10 → stall_o/busy_o drop immediately; mfhi/mflo read 0; a new mult afterwards completes correctly.
